// File: rtl/alu_multicycle.sv
// alu_multicycle: MIPS datapath ALU with logic/arith/shift/compare ops completing
// in one cycle and iterative multiply/divide, behind valid/ready handshakes.
module alu_multicycle #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = SHW + 1;

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_XOR   = 4'd3;
  localparam logic [3:0] OP_NOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SUB   = 4'd6;
  localparam logic [3:0] OP_SLT   = 4'd7;
  localparam logic [3:0] OP_SLTU  = 4'd8;
  localparam logic [3:0] OP_SRL   = 4'd9;
  localparam logic [3:0] OP_SRA   = 4'd10;
  localparam logic [3:0] OP_MULT  = 4'd11;
  localparam logic [3:0] OP_MULTU = 4'd12;
  localparam logic [3:0] OP_DIV   = 4'd13;
  localparam logic [3:0] OP_DIVU  = 4'd14;

  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;       // product high / partial remainder
  logic [WIDTH-1:0] quo;       // multiplier (shifting out) / dividend->quotient
  logic [WIDTH-1:0] opnd;      // multiplicand / divisor magnitude
  logic             div_mode;
  logic             neg_lo;    // negate product, or negate quotient
  logic             neg_hi;    // negate remainder
  logic             min_ovf;

  // Single-cycle datapath
  logic [WIDTH-1:0]        sum_c, diff_c, sc_lo_c;
  logic signed [WIDTH-1:0] sra_c;
  logic [SHW-1:0]          shamt_c;
  logic                    sc_ovf_c;

  assign sum_c   = a + b;
  assign diff_c  = a - b;
  assign shamt_c = b[SHW-1:0];
  assign sra_c   = $signed(a) >>> shamt_c;

  // Result and overflow for ops that complete in one cycle
  always_comb begin
    sc_lo_c  = '0;
    sc_ovf_c = 1'b0;
    case (op)
      OP_AND:  sc_lo_c = a & b;
      OP_OR:   sc_lo_c = a | b;
      OP_XOR:  sc_lo_c = a ^ b;
      OP_NOR:  sc_lo_c = ~(a | b);
      OP_ADD: begin
        sc_lo_c  = sum_c;
        sc_ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_lo_c  = diff_c;
        sc_ovf_c = (a[WIDTH-1] != b[WIDTH-1]) && (diff_c[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  sc_lo_c = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: sc_lo_c = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  sc_lo_c = a << shamt_c;
      OP_SRL:  sc_lo_c = a >> shamt_c;
      OP_SRA:  sc_lo_c = sra_c;
      default: begin
        sc_lo_c  = '0;
        sc_ovf_c = 1'b0;
      end
    endcase
  end

  // Operand classification and magnitudes for the iterative unit
  logic             is_long_c, is_div_c, is_signed_c, dbz_c, a_neg_c, b_neg_c;
  logic [WIDTH-1:0] a_mag_c, b_mag_c;

  assign is_long_c   = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  assign is_div_c    = (op == OP_DIV) || (op == OP_DIVU);
  assign is_signed_c = (op == OP_MULT) || (op == OP_DIV);
  assign dbz_c       = is_div_c && (b == '0);
  assign a_neg_c     = is_signed_c && a[WIDTH-1];
  assign b_neg_c     = is_signed_c && b[WIDTH-1];
  assign a_mag_c     = a_neg_c ? -a : a;
  assign b_mag_c     = b_neg_c ? -b : b;

  // One shift-add or restoring-subtract step on the working registers
  logic [WIDTH:0]   madd_c, shifted_c, sub_c;
  logic             ge_c;
  logic [WIDTH-1:0] step_acc_c, step_quo_c;

  assign madd_c    = {1'b0, acc} + (quo[0] ? {1'b0, opnd} : '0);
  assign shifted_c = {acc, quo[WIDTH-1]};
  assign sub_c     = shifted_c - {1'b0, opnd};
  assign ge_c      = ~sub_c[WIDTH];

  always_comb begin
    step_acc_c = '0;
    step_quo_c = '0;
    if (div_mode) begin
      step_acc_c = ge_c ? sub_c[WIDTH-1:0] : shifted_c[WIDTH-1:0];
      step_quo_c = {quo[WIDTH-2:0], ge_c};
    end else begin
      step_acc_c = madd_c[WIDTH:1];
      step_quo_c = {madd_c[0], quo[WIDTH-1:1]};
    end
  end

  // Sign correction applied to the result of the final step
  logic [2*WIDTH-1:0] prod_c, prod_fix_c;
  logic [WIDTH-1:0]   fin_lo_c, fin_hi_c;

  assign prod_c     = {step_acc_c, step_quo_c};
  assign prod_fix_c = neg_lo ? -prod_c : prod_c;

  always_comb begin
    fin_lo_c = '0;
    fin_hi_c = '0;
    if (div_mode) begin
      fin_lo_c = neg_lo ? -step_quo_c : step_quo_c;
      fin_hi_c = neg_hi ? -step_acc_c : step_acc_c;
    end else begin
      fin_lo_c = prod_fix_c[WIDTH-1:0];
      fin_hi_c = prod_fix_c[2*WIDTH-1:WIDTH];
    end
  end

  // Control FSM, iterative datapath registers and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      quo         <= '0;
      opnd        <= '0;
      div_mode    <= 1'b0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
      min_ovf     <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      result_lo   <= '0;
      result_hi   <= '0;
      zero        <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (is_long_c && !dbz_c) begin
              div_mode <= is_div_c;
              acc      <= '0;
              quo      <= is_div_c ? a_mag_c : b_mag_c;
              opnd     <= is_div_c ? b_mag_c : a_mag_c;
              neg_lo   <= a_neg_c ^ b_neg_c;
              neg_hi   <= is_div_c && a_neg_c;
              min_ovf  <= (op == OP_DIV) && (a == SMIN) && (b == '1);
              cnt      <= CW'(WIDTH);
              state    <= BUSY;
            end else begin
              result_lo   <= dbz_c ? '1 : sc_lo_c;
              result_hi   <= dbz_c ? a : '0;
              zero        <= dbz_c ? 1'b0 : (sc_lo_c == '0);
              overflow    <= dbz_c ? 1'b0 : sc_ovf_c;
              div_by_zero <= dbz_c;
              out_valid   <= 1'b1;
              state       <= DONE;
            end
          end
        end
        BUSY: begin
          acc <= step_acc_c;
          quo <= step_quo_c;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            result_lo   <= fin_lo_c;
            result_hi   <= fin_hi_c;
            zero        <= (fin_lo_c == '0);
            overflow    <= min_ovf;
            div_by_zero <= 1'b0;
            out_valid   <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
